call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, width of stored return addresses (matches 19-bit PC).
REQ-002 SHALL have parameter DEPTH, default 8, number of stack entries; power of two, 2..64.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port hazard  input  1  pipeline stall from hazard unit; blocks all stack operations while high.
REQ-006 SHALL have port push  input  1  call request from control decode.
REQ-007 SHALL have port pop  input  1  return request from control decode (asserted with ret).
REQ-008 SHALL have port ret_addr_in  input  ADDR_W  return address (PC+1) to save on push.
REQ-009 SHALL have port ret_pc  output  ADDR_W  registered popped return address.
REQ-010 SHALL have port ret_valid  output  1  one-cycle pulse: ret_pc holds a freshly popped address.
REQ-011 SHALL have port full  output  1  high when occupancy == DEPTH.
REQ-012 SHALL have port empty  output  1  high when occupancy == 0.
REQ-013 SHALL have port depth_cnt  output  clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky error: push attempted while full.
REQ-015 SHALL have port underflow  output  1  sticky error: pop attempted while empty.
REQ-016 SHALL have port err_clr  input  1  synchronous clear of overflow/underflow.

Function
REQ-017 SHALL treat an operation as accepted only on a rising edge where hazard == 0.
REQ-018 SHALL, on accepted push alone and not full, write ret_addr_in at index depth_cnt and increment depth_cnt by 1.
REQ-019 SHALL, on accepted pop alone and not empty, load ret_pc with entry depth_cnt-1, decrement depth_cnt, and pulse ret_valid high for exactly the next cycle.
REQ-020 SHALL, on accepted push and pop together with depth_cnt > 0, load ret_pc with the current top, overwrite the top with ret_addr_in, leave depth_cnt unchanged, and pulse ret_valid.
REQ-021 SHALL, on accepted push and pop together with empty, treat as pop-while-empty (underflow) and discard the push.
REQ-022 SHALL, on push while full, leave storage and depth_cnt unchanged (push dropped).
REQ-023 SHALL, on pop while empty, leave ret_pc unchanged and keep ret_valid low.
REQ-024 SHALL hold ret_pc stable between accepted pops; ret_valid low in every cycle not following an accepted pop.
REQ-025 SHALL have a latency of one clock from accepted pop to ret_valid/ret_pc.
REQ-026 SHALL derive full and empty combinationally from depth_cnt.
REQ-027 SHALL give err_clr priority over a same-cycle new error event (flags read 0 next cycle).

Reset
REQ-028 SHALL, while rst_n == 0, asynchronously force depth_cnt = 0, ret_pc = 0, ret_valid = 0, overflow = 0, underflow = 0; empty = 1, full = 0.
REQ-029 SHALL not require storage array reset; contents below depth_cnt are undefined after reset.
REQ-030 SHALL, on reset assertion mid-operation, abandon any in-flight pop (no ret_valid after release).

Configuration
REQ-031 SHALL honour macro CALL_STACK_ERR_EN: when defined, overflow/underflow are sticky flags per REQ-014/015/027.
REQ-032 SHALL, when CALL_STACK_ERR_EN is undefined, tie overflow and underflow to 0, ignore err_clr, and keep drop behaviour of REQ-021..023 unchanged.

Verification
REQ-033 SHALL cover: reset, push 0x00010, 0x00020, 0x00030, then 3 pops -> ret_pc 0x00030, 0x00020, 0x00010 each with one-cycle ret_valid; empty=1 after.
REQ-034 SHALL cover: 9 pushes with DEPTH=8 -> full=1 after 8th, depth_cnt=8, 9th dropped, overflow=1 (ERR_EN); next pop returns 8th address.
REQ-035 SHALL cover: pop when empty -> ret_valid stays 0, ret_pc unchanged, underflow=1; err_clr pulse -> underflow=0.
REQ-036 SHALL cover: depth 2 (tops 0x00100), push 0x00200 with pop same cycle -> ret_pc=0x00100, depth_cnt=2, following pop returns 0x00200.
REQ-037 SHALL cover: push/pop with hazard=1 -> no change to depth_cnt, ret_valid 0; same request repeated with hazard=0 -> accepted.
REQ-038 SHALL cover: rst_n asserted low mid-cycle after accepted pop edge at depth 3 -> depth_cnt=0, ret_valid=0 immediately, empty=1.

Source files
------------

// File: rtl/call_stack.sv
// Hardware return-address stack for call/ret with same-cycle push+pop swap.
// Optional sticky overflow/underflow flags are enabled by defining CALL_STACK_ERR_EN.
module call_stack #(
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hazard,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        ret_addr_in,
  input  logic                     err_clr,
  output logic [ADDR_W-1:0]        ret_pc,
  output logic                     ret_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth_cnt,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  depth_reg;
  logic [CNT_W-1:0]  depth_m1;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] ret_pc_reg;
  logic              ret_valid_reg;
  logic              accept;
  logic              pop_ok;
  logic              push_ok;
  logic              swap;
  logic              wr_en;

  assign full    = (depth_reg == CNT_W'(DEPTH));
  assign empty   = (depth_reg == '0);
  assign depth_m1 = depth_reg - CNT_W'(1);
  assign top_idx  = depth_m1[IDX_W-1:0];

  // A pop with an empty stack swallows any simultaneous push.
  assign accept  = !hazard;
  assign pop_ok  = accept && pop && !empty;
  assign push_ok = accept && push && !pop && !full;
  assign swap    = pop_ok && push;
  assign wr_en   = push_ok || swap;
  assign wr_idx  = swap ? top_idx : depth_reg[IDX_W-1:0];

  // Storage carries no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= ret_addr_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_reg     <= '0;
      ret_pc_reg    <= '0;
      ret_valid_reg <= 1'b0;
    end else begin
      ret_valid_reg <= pop_ok;
      if (pop_ok)
        ret_pc_reg <= mem[top_idx];
      if (push_ok)
        depth_reg <= depth_reg + CNT_W'(1);
      else if (pop_ok && !push)
        depth_reg <= depth_m1;
    end
  end

  assign ret_pc    = ret_pc_reg;
  assign ret_valid = ret_valid_reg;
  assign depth_cnt = depth_reg;

`ifdef CALL_STACK_ERR_EN
  logic overflow_reg;
  logic underflow_reg;
  logic ovf_evt;
  logic unf_evt;

  assign ovf_evt = accept && push && !pop && full;
  assign unf_evt = accept && pop && empty;

  // Clear wins over an error raised in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (err_clr) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (ovf_evt)
        overflow_reg <= 1'b1;
      if (unf_evt)
        underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: vector table for the main sequence, hand-written
// steps for swap-at-empty, hazard stalls and mid-operation reset.
module tb_call_stack;

`ifdef CALL_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hazard = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [18:0] ret_addr_in = '0;
  logic        err_clr = 1'b0;
  logic [18:0] ret_pc;
  logic        ret_valid;
  logic        full;
  logic        empty;
  logic [3:0]  depth_cnt;
  logic        overflow;
  logic        underflow;

  int nchk = 0;
  int nerr = 0;

  call_stack #(.ADDR_W(19), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .hazard(hazard), .push(push), .pop(pop),
    .ret_addr_in(ret_addr_in), .err_clr(err_clr), .ret_pc(ret_pc),
    .ret_valid(ret_valid), .full(full), .empty(empty), .depth_cnt(depth_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hz, pu, po, clr;
    logic [18:0] addr;
    int          dep;
    logic        rv;
    logic [18:0] pc;
    logic        fu, em, ov, un;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic h, input logic pu, input logic po, input logic cl,
                      input logic [18:0] a);
    hazard = h; push = pu; pop = po; err_clr = cl; ret_addr_in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hazard = 0; push = 0; pop = 0; err_clr = 0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic add(input logic hz, input logic pu, input logic po, input logic clr,
                     input logic [18:0] addr, input int dep, input logic rv,
                     input logic [18:0] pc, input logic ov, input logic un);
    vec_t v;
    v = '{hz, pu, po, clr, addr, dep, rv, pc, (dep == 8), (dep == 0),
          ov & ERR_EN, un & ERR_EN};
    vecs.push_back(v);
  endtask

  initial begin
    // Main sequence: LIFO order, empty pop, fill past full, clear priority.
    add(0,1,0,0,19'h00010, 1,0,19'h0,     0,0);
    add(0,1,0,0,19'h00020, 2,0,19'h0,     0,0);
    add(0,1,0,0,19'h00030, 3,0,19'h0,     0,0);
    add(0,0,1,0,19'h0,     2,1,19'h00030, 0,0);
    add(0,0,1,0,19'h0,     1,1,19'h00020, 0,0);
    add(0,0,1,0,19'h0,     0,1,19'h00010, 0,0);
    add(0,0,0,0,19'h0,     0,0,19'h00010, 0,0);
    add(0,0,1,0,19'h0,     0,0,19'h00010, 0,1);
    add(0,0,0,1,19'h0,     0,0,19'h00010, 0,0);
    for (int i = 1; i <= 8; i++)
      add(0,1,0,0,19'(32'h100 + i), i,0,19'h00010, 0,0);
    add(0,1,0,0,19'h00109, 8,0,19'h00010, 1,0);
    add(0,0,1,0,19'h0,     7,1,19'h00108, 1,0);
    add(0,1,0,0,19'h00200, 8,0,19'h00108, 1,0);
    add(0,1,0,1,19'h00201, 8,0,19'h00108, 0,0);
    add(0,0,1,0,19'h0,     7,1,19'h00200, 0,0);

    rst_n = 1'b0;
    #12;
    chk("rst_depth", 32'(depth_cnt), 0);
    chk("rst_ret_valid", 32'(ret_valid), 0);
    chk("rst_ret_pc", 32'(ret_pc), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_flags", {30'b0, overflow, underflow}, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].hz, vecs[i].pu, vecs[i].po, vecs[i].clr, vecs[i].addr);
      $display("vec %0d: push=%0b pop=%0b addr=%05h -> depth=%0d rv=%0b pc=%05h ov=%0b un=%0b",
               i, vecs[i].pu, vecs[i].po, vecs[i].addr, depth_cnt, ret_valid, ret_pc,
               overflow, underflow);
      chk($sformatf("v%0d_depth", i), 32'(depth_cnt), 32'(vecs[i].dep));
      chk($sformatf("v%0d_rv", i), 32'(ret_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d_pc", i), 32'(ret_pc), 32'(vecs[i].pc));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].fu));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].em));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ov));
      chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(vecs[i].un));
    end

    // Swap at depth 2, then push+pop while empty.
    do_reset();
    step(0,1,0,0,19'h00080);
    step(0,1,0,0,19'h00100);
    step(0,1,1,0,19'h00200);
    $display("swap: depth=%0d rv=%0b pc=%05h", depth_cnt, ret_valid, ret_pc);
    chk("swap_pc", 32'(ret_pc), 32'h100);
    chk("swap_rv", 32'(ret_valid), 1);
    chk("swap_depth", 32'(depth_cnt), 2);
    step(0,0,1,0,19'h0);
    $display("pop after swap: depth=%0d rv=%0b pc=%05h", depth_cnt, ret_valid, ret_pc);
    chk("post_swap_pc", 32'(ret_pc), 32'h200);
    chk("post_swap_rv", 32'(ret_valid), 1);
    step(0,0,1,0,19'h0);
    chk("bottom_pc", 32'(ret_pc), 32'h80);
    step(0,1,1,0,19'h00300);
    $display("push+pop empty: depth=%0d rv=%0b pc=%05h un=%0b",
             depth_cnt, ret_valid, ret_pc, underflow);
    chk("pp_empty_depth", 32'(depth_cnt), 0);
    chk("pp_empty_rv", 32'(ret_valid), 0);
    chk("pp_empty_pc", 32'(ret_pc), 32'h80);
    chk("pp_empty_unf", 32'(underflow), 32'(ERR_EN));

    // Hazard blocks push and pop; the same requests go through once it drops.
    do_reset();
    step(0,1,0,0,19'h00011);
    step(1,1,0,0,19'h00022);
    $display("hazard push: depth=%0d", depth_cnt);
    chk("hz_push_depth", 32'(depth_cnt), 1);
    step(1,0,1,0,19'h0);
    $display("hazard pop: depth=%0d rv=%0b", depth_cnt, ret_valid);
    chk("hz_pop_depth", 32'(depth_cnt), 1);
    chk("hz_pop_rv", 32'(ret_valid), 0);
    step(0,1,0,0,19'h00022);
    chk("nohz_push_depth", 32'(depth_cnt), 2);
    step(0,0,1,0,19'h0);
    $display("released pop: depth=%0d rv=%0b pc=%05h", depth_cnt, ret_valid, ret_pc);
    chk("nohz_pop_rv", 32'(ret_valid), 1);
    chk("nohz_pop_pc", 32'(ret_pc), 32'h22);

    // Reset asserted mid-cycle right after an accepted pop at depth 3.
    do_reset();
    step(0,1,0,0,19'h00001);
    step(0,1,0,0,19'h00002);
    step(0,1,0,0,19'h00003);
    step(0,0,1,0,19'h0);
    chk("pre_rst_rv", 32'(ret_valid), 1);
    chk("pre_rst_depth", 32'(depth_cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: depth=%0d rv=%0b empty=%0b pc=%05h",
             depth_cnt, ret_valid, empty, ret_pc);
    chk("arst_depth", 32'(depth_cnt), 0);
    chk("arst_rv", 32'(ret_valid), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_pc", 32'(ret_pc), 0);
    pop = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(0,0,0,0,19'h0);
    chk("post_rst_rv", 32'(ret_valid), 0);
    chk("post_rst_depth", 32'(depth_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
